// File: rtl/axis_peak_arb.sv
// Per-tag burst peak trackers feeding 1-entry holding registers, merged onto a
// single AXI-Stream master by a round-robin arbiter.
module axis_peak_arb #(
    parameter int  NUM_TAGS      = 20,
    parameter int  CHANNEL_WIDTH = 64,
    parameter int  NUM_CHANNELS  = 4,
    parameter int  MAG_WIDTH     = 32,
    parameter int  MAX_BURST     = 32,
    localparam int DATA_WIDTH    = CHANNEL_WIDTH * NUM_CHANNELS,
    localparam int IW            = $clog2(MAX_BURST),
    localparam int TW            = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
    localparam int RW            = 1 + IW + MAG_WIDTH + DATA_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [MAG_WIDTH-1:0]           peak_threshold,
    input  logic [NUM_TAGS-1:0]            tag_enable,
    input  logic                           ovf_clear,
    output logic [NUM_TAGS-1:0]            ovf_flags,
    input  logic [NUM_TAGS-1:0]            s_axis_tvalid,
    output logic [NUM_TAGS-1:0]            s_axis_tready,
    input  logic [NUM_TAGS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_TAGS*MAG_WIDTH-1:0]  s_axis_tdata_abs,
    input  logic [NUM_TAGS-1:0]            s_axis_tlast,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [RW-1:0]                  m_axis_tdata,
    output logic [TW-1:0]                  m_axis_tuser,
    output logic                           m_axis_tlast
);

    localparam logic [IW:0] CNT_MAX = (IW+1)'(MAX_BURST);
    localparam logic [IW:0] CNT_ONE = (IW+1)'(1);

    logic [IW:0]            cnt_q        [NUM_TAGS];
    logic [IW:0]            cnt_d        [NUM_TAGS];
    logic [NUM_TAGS-1:0]    best_valid_q, best_valid_d;
    logic [MAG_WIDTH-1:0]   best_mag_q   [NUM_TAGS];
    logic [MAG_WIDTH-1:0]   best_mag_d   [NUM_TAGS];
    logic [IW-1:0]          best_idx_q   [NUM_TAGS];
    logic [IW-1:0]          best_idx_d   [NUM_TAGS];
    logic [DATA_WIDTH-1:0]  best_data_q  [NUM_TAGS];
    logic [DATA_WIDTH-1:0]  best_data_d  [NUM_TAGS];
    logic [NUM_TAGS-1:0]    trunc_q, trunc_d;

    logic [NUM_TAGS-1:0]    hold_valid_q, hold_valid_d;
    logic [RW-1:0]          hold_rec_q   [NUM_TAGS];
    logic [RW-1:0]          hold_rec_d   [NUM_TAGS];
    logic [NUM_TAGS-1:0]    ovf_q, ovf_d;
    logic [TW-1:0]          ptr_q, ptr_d;
    logic                   out_valid_q, out_valid_d;
    logic [RW-1:0]          out_data_q, out_data_d;
    logic [TW-1:0]          out_user_q, out_user_d;

    logic [NUM_TAGS-1:0]    push_s;
    logic [RW-1:0]          rec_s        [NUM_TAGS];
    logic [NUM_TAGS-1:0]    grant_s;
    logic [NUM_TAGS-1:0]    ovf_set_s;
    logic                   grant_en_s;
    logic                   found_s;
    logic [TW-1:0]          gnt_idx_s;

    logic                   nb_valid_s;
    logic [MAG_WIDTH-1:0]   nb_mag_s;
    logic [IW-1:0]          nb_idx_s;
    logic [DATA_WIDTH-1:0]  nb_data_s;
    logic                   nb_trunc_s;
    logic [IW:0]            nb_cnt_s;
    logic [MAG_WIDTH-1:0]   beat_mag_s;

    function automatic logic [TW-1:0] rr_index(input logic [TW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_TAGS) begin
            s = s - NUM_TAGS;
        end else begin
            s = s;
        end
        return TW'(s);
    endfunction

    // Per-tag tracker update and record formation on tlast
    always_comb begin
        cnt_d        = cnt_q;
        best_valid_d = best_valid_q;
        best_mag_d   = best_mag_q;
        best_idx_d   = best_idx_q;
        best_data_d  = best_data_q;
        trunc_d      = trunc_q;
        push_s       = '0;
        rec_s        = '{default: '0};
        nb_valid_s   = 1'b0;
        nb_mag_s     = '0;
        nb_idx_s     = '0;
        nb_data_s    = '0;
        nb_trunc_s   = 1'b0;
        nb_cnt_s     = '0;
        beat_mag_s   = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            nb_valid_s = best_valid_q[i];
            nb_mag_s   = best_mag_q[i];
            nb_idx_s   = best_idx_q[i];
            nb_data_s  = best_data_q[i];
            nb_trunc_s = trunc_q[i];
            nb_cnt_s   = cnt_q[i];
            beat_mag_s = s_axis_tdata_abs[i*MAG_WIDTH +: MAG_WIDTH];
            if (!tag_enable[i]) begin
                cnt_d[i]        = '0;
                best_valid_d[i] = 1'b0;
                best_mag_d[i]   = '0;
                best_idx_d[i]   = '0;
                best_data_d[i]  = '0;
                trunc_d[i]      = 1'b0;
            end else if (s_axis_tvalid[i]) begin
                if (nb_cnt_s < CNT_MAX) begin
                    // strict > keeps the earliest beat on equal magnitudes
                    if ((beat_mag_s >= peak_threshold) && (!nb_valid_s || (beat_mag_s > nb_mag_s))) begin
                        nb_valid_s = 1'b1;
                        nb_mag_s   = beat_mag_s;
                        nb_idx_s   = nb_cnt_s[IW-1:0];
                        nb_data_s  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        nb_valid_s = nb_valid_s;
                    end
                    nb_cnt_s = nb_cnt_s + CNT_ONE;
                end else begin
                    nb_trunc_s = 1'b1;
                end
                if (s_axis_tlast[i]) begin
                    push_s[i]       = nb_valid_s;
                    rec_s[i]        = {nb_trunc_s, nb_idx_s, nb_mag_s, nb_data_s};
                    cnt_d[i]        = '0;
                    best_valid_d[i] = 1'b0;
                    best_mag_d[i]   = '0;
                    best_idx_d[i]   = '0;
                    best_data_d[i]  = '0;
                    trunc_d[i]      = 1'b0;
                end else begin
                    cnt_d[i]        = nb_cnt_s;
                    best_valid_d[i] = nb_valid_s;
                    best_mag_d[i]   = nb_mag_s;
                    best_idx_d[i]   = nb_idx_s;
                    best_data_d[i]  = nb_data_s;
                    trunc_d[i]      = nb_trunc_s;
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Round-robin arbitration, holding registers, overflow flags, output register
    always_comb begin
        grant_en_s   = !out_valid_q || m_axis_tready;
        found_s      = 1'b0;
        gnt_idx_s    = '0;
        grant_s      = '0;
        ovf_set_s    = '0;
        hold_valid_d = hold_valid_q;
        hold_rec_d   = hold_rec_q;
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_user_d   = out_user_q;
        for (int k = 0; k < NUM_TAGS; k++) begin
            if (!found_s && hold_valid_q[rr_index(ptr_q, k)]) begin
                found_s   = 1'b1;
                gnt_idx_s = rr_index(ptr_q, k);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NUM_TAGS; i++) begin
            grant_s[i] = grant_en_s && found_s && (gnt_idx_s == TW'(i));
            if (push_s[i]) begin
                if (hold_valid_q[i] && !grant_s[i]) begin
                    ovf_set_s[i] = 1'b1;
                end else begin
                    hold_valid_d[i] = 1'b1;
                    hold_rec_d[i]   = rec_s[i];
                end
            end else if (grant_s[i]) begin
                hold_valid_d[i] = 1'b0;
            end else begin
                hold_valid_d[i] = hold_valid_q[i];
            end
        end
        if (grant_en_s && found_s) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_rec_q[gnt_idx_s];
            out_user_d  = gnt_idx_s;
            ptr_d       = rr_index(gnt_idx_s, 1);
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        ovf_d = (ovf_q & ~{NUM_TAGS{ovf_clear}}) | ovf_set_s;
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                cnt_q[i]       <= '0;
                best_mag_q[i]  <= '0;
                best_idx_q[i]  <= '0;
                best_data_q[i] <= '0;
                hold_rec_q[i]  <= '0;
            end
            best_valid_q <= '0;
            trunc_q      <= '0;
            hold_valid_q <= '0;
            ovf_q        <= '0;
            ptr_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_user_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            best_mag_q   <= best_mag_d;
            best_idx_q   <= best_idx_d;
            best_data_q  <= best_data_d;
            hold_rec_q   <= hold_rec_d;
            best_valid_q <= best_valid_d;
            trunc_q      <= trunc_d;
            hold_valid_q <= hold_valid_d;
            ovf_q        <= ovf_d;
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_user_q   <= out_user_d;
        end
    end

    assign s_axis_tready = {NUM_TAGS{~rst}};
    assign ovf_flags     = ovf_q;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tlast  = out_valid_q;

endmodule
